// File: rtl/bdc_pkg.sv
// Shared types and mapping constants for the
// barrel distortion corrector.
package bdc_pkg;

    typedef enum logic {
        LOAD,
        OUTPUT
    } state_e;

    localparam int MAP_W  = 48;
    localparam int FRAC_W = 16;
    localparam int R2N_SH = 16;
    localparam int K1_SH  = 6;

    typedef logic signed [MAP_W-1:0] map_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } meta_t;

    function automatic longint rmax2(input int w, input int h);
        return longint'(w - 1) * longint'(w - 1)
             + longint'(h - 1) * longint'(h - 1);
    endfunction

    // Normalises r2 to Q1.15 after a >>16.
    function automatic longint recip(input int w, input int h);
        return (longint'(1) <<< 31) / rmax2(w, h);
    endfunction

endpackage

// File: rtl/bdc_frame_ram.sv
// Frame store: one write port, one registered read port.
// Contents are never cleared.
module bdc_frame_ram #(
    parameter int DEPTH = 12800,
    parameter int DW    = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/barrel_distortion_correction.sv
// Captures one frame, then replays it through a radial inverse
// mapping with nearest-neighbour sampling (4-stage pipeline).
module barrel_distortion_correction
    import bdc_pkg::*;
#(
    parameter int         WIDTH         = 128,
    parameter int         HEIGHT        = 100,
    parameter int         DATA_WIDTH    = 24,
    parameter logic [7:0] DISTORTION_K1 = 8'hE0,
    parameter int         BUFFER_LINES  = HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);

    localparam int   NPIX  = WIDTH * BUFFER_LINES;
    localparam int   AW    = $clog2(NPIX);
    localparam int   XW    = $clog2(WIDTH + 1);
    localparam int   YW    = $clog2(HEIGHT + 1);
    localparam map_t RECIP = map_t'(recip(WIDTH, HEIGHT));
    localparam map_t K1    = map_t'(signed'(DISTORTION_K1));
    localparam map_t ONE   = map_t'(1) <<< FRAC_W;
    localparam map_t HALF  = map_t'(1) <<< (FRAC_W - 1);
    localparam map_t W_S   = map_t'(WIDTH);
    localparam map_t H_S   = map_t'(HEIGHT);

    if (BUFFER_LINES != HEIGHT) begin : g_bad_cfg
        $error("BUFFER_LINES must equal HEIGHT");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [XW-1:0] gx_q, gx_d;
    logic [YW-1:0] gy_q, gy_d;
    logic          gon_q, gon_d;

    logic          wr_fire, wr_end, advance, out_fire;
    logic [AW-1:0] wr_addr;

    assign s_axis_tready = (state_q == LOAD);
    assign wr_fire  = s_axis_tvalid & s_axis_tready;
    assign wr_addr  = s_axis_tuser ? '0 : wptr_q;
    assign wr_end   = s_axis_tlast || (wr_addr == AW'(NPIX - 1));

    meta_t m1_q, m2_q, m3_q, m4_q, m1_d;
    logic  in3_q, in4_q;

    assign advance  = !(m4_q.valid && !m_axis_tready);
    assign out_fire = m4_q.valid && m_axis_tready;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        gon_d   = gon_q;
        unique case (state_q)
            LOAD: begin
                if (wr_fire) begin
                    wptr_d = wr_addr + 1'b1;
                    if (wr_end) begin
                        state_d = OUTPUT;
                        wptr_d  = '0;
                        gx_d    = '0;
                        gy_d    = '0;
                        gon_d   = 1'b1;
                    end
                end
            end
            OUTPUT: begin
                if (advance && gon_q) begin
                    if (gx_q == XW'(WIDTH - 1)) begin
                        gx_d = '0;
                        if (gy_q == YW'(HEIGHT - 1)) begin
                            gon_d = 1'b0;
                        end else begin
                            gy_d = gy_q + 1'b1;
                        end
                    end else begin
                        gx_d = gx_q + 1'b1;
                    end
                end
                if (out_fire && m4_q.last) begin
                    state_d = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            gon_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            gon_q   <= gon_d;
        end
    end

    // Stage 1: centred doubled coordinates and squared radius.
    map_t dx_c, dy_c, r2_c;
    assign dx_c = (map_t'(gx_q) <<< 1) - map_t'(WIDTH - 1);
    assign dy_c = (map_t'(gy_q) <<< 1) - map_t'(HEIGHT - 1);
    assign r2_c = dx_c * dx_c + dy_c * dy_c;
    assign m1_d = '{
        valid: gon_q,
        first: (gx_q == '0) && (gy_q == '0),
        last:  (gx_q == XW'(WIDTH - 1)) && (gy_q == YW'(HEIGHT - 1))
    };

    map_t dxa_q, dya_q, r2_q;

    // Stage 2: normalised radius and Q.16 scale factor.
    map_t r2n_c, scale_c;
    assign r2n_c   = (r2_q * RECIP) >>> R2N_SH;
    assign scale_c = ONE + ((K1 * r2n_c) >>> K1_SH);

    map_t dxb_q, dyb_q, scale_q;

    // Stage 3: rounded source coordinate, bounds test, address.
    map_t          sx2_c, sy2_c, sx_c, sy_c;
    logic          in_c;
    logic [AW-1:0] addr_c, addr3_q;

    always_comb begin
        sx2_c  = (dxb_q * scale_q + HALF) >>> FRAC_W;
        sy2_c  = (dyb_q * scale_q + HALF) >>> FRAC_W;
        sx_c   = (sx2_c + W_S) >>> 1;
        sy_c   = (sy2_c + H_S) >>> 1;
        in_c   = (sx_c >= 0) && (sx_c < W_S)
              && (sy_c >= 0) && (sy_c < H_S);
        addr_c = in_c ? AW'(sy_c * W_S + sx_c) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            m4_q    <= '0;
            dxa_q   <= '0;
            dya_q   <= '0;
            r2_q    <= '0;
            dxb_q   <= '0;
            dyb_q   <= '0;
            scale_q <= '0;
            in3_q   <= 1'b0;
            addr3_q <= '0;
            in4_q   <= 1'b0;
        end else if (advance) begin
            m1_q    <= m1_d;
            dxa_q   <= dx_c;
            dya_q   <= dy_c;
            r2_q    <= r2_c;
            m2_q    <= m1_q;
            dxb_q   <= dxa_q;
            dyb_q   <= dya_q;
            scale_q <= scale_c;
            m3_q    <= m2_q;
            in3_q   <= in_c;
            addr3_q <= addr_c;
            m4_q    <= m3_q;
            in4_q   <= in3_q;
        end
    end

    // Stage 4 is the RAM read; rdata holds while stalled.
    logic [DATA_WIDTH-1:0] rdata;

    bdc_frame_ram #(
        .DEPTH(NPIX),
        .DW   (DATA_WIDTH),
        .AW   (AW)
    ) u_ram (
        .clk    (clk),
        .we_i   (wr_fire),
        .waddr_i(wr_addr),
        .wdata_i(s_axis_tdata),
        .re_i   (advance),
        .raddr_i(addr3_q),
        .rdata_o(rdata)
    );

    assign m_axis_tvalid = m4_q.valid;
    assign m_axis_tuser  = m4_q.valid & m4_q.first;
    assign m_axis_tlast  = m4_q.valid & m4_q.last;
    assign m_axis_tdata  = (m4_q.valid && in4_q) ? rdata : '0;

endmodule

// File: tb/tb_barrel_distortion_correction.sv
// Directed bench: identity and barrel instances side by side,
// ramp frames, stalls, sparse input and mid-frame reset.
module tb_barrel_distortion_correction;

    localparam int W  = 128;
    localparam int H  = 100;
    localparam int N  = W * H;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] s_tdata;
    logic s_tvalid, s_tlast, s_tuser;
    logic s_tready_e, s_tready_z;
    logic [DW-1:0] m_tdata_e, m_tdata_z;
    logic m_tvalid_e, m_tvalid_z;
    logic m_tlast_e, m_tlast_z;
    logic m_tuser_e, m_tuser_z;
    logic m_tready;

    always #5 clk = ~clk;

    barrel_distortion_correction #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW),
        .DISTORTION_K1(8'hE0), .BUFFER_LINES(H)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .s_axis_tready(s_tready_e),
        .m_axis_tdata(m_tdata_e), .m_axis_tvalid(m_tvalid_e),
        .m_axis_tlast(m_tlast_e), .m_axis_tuser(m_tuser_e),
        .m_axis_tready(m_tready)
    );

    barrel_distortion_correction #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW),
        .DISTORTION_K1(8'h00), .BUFFER_LINES(H)
    ) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .s_axis_tready(s_tready_z),
        .m_axis_tdata(m_tdata_z), .m_axis_tvalid(m_tvalid_z),
        .m_axis_tlast(m_tlast_z), .m_axis_tuser(m_tuser_z),
        .m_axis_tready(m_tready)
    );

    typedef struct {
        int x;
        int y;
        int src;
    } vec_t;

    vec_t tbl [7];

    int checks = 0;
    int failures = 0;
    int load_rdy_err, load_mv_err, hs_timeout;
    int stall_err, user_err, last_err, sync_err;
    int ncollected;
    bit collect_done;

    logic [DW-1:0] ref_e [N];
    logic [DW-1:0] out_e [N];
    logic [DW-1:0] out_z [N];

    task automatic check(input string name, input longint got,
                         input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic clear_errs();
        load_rdy_err = 0;
        load_mv_err  = 0;
        hs_timeout   = 0;
        stall_err    = 0;
        user_err     = 0;
        last_err     = 0;
        sync_err     = 0;
    endtask

    task automatic sample_load();
        if (!s_tready_e || !s_tready_z) load_rdy_err++;
        if (m_tvalid_e || m_tvalid_z) load_mv_err++;
    endtask

    // Called and returns at posedge+1.
    task automatic send(input int count, input bit sparse,
                        input bit user0, input logic [DW-1:0] xv);
        int  t;
        bit  rdy;
        for (int i = 0; i < count; i++) begin
            if (sparse) begin
                s_tvalid = 1'b0;
                @(negedge clk);
                sample_load();
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = DW'(i) ^ xv;
            s_tuser  = user0 && (i == 0);
            s_tlast  = (i == N - 1);
            t = 0;
            do begin
                @(negedge clk);
                sample_load();
                rdy = s_tready_e;
                @(posedge clk);
                #1;
                t++;
            end while (!rdy && t < 20);
            if (!rdy) hs_timeout++;
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic collect(input bit rnd);
        int k = 0;
        int t = 0;
        bit held = 1'b0;
        logic [DW-1:0] hd;
        logic hu, hl;
        collect_done = 1'b0;
        while (!collect_done && t < 60000) begin
            m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            t++;
            if (held) begin
                if (!m_tvalid_e || m_tdata_e != hd ||
                    m_tuser_e != hu || m_tlast_e != hl)
                    stall_err++;
            end
            held = m_tvalid_e && !m_tready;
            hd = m_tdata_e;
            hu = m_tuser_e;
            hl = m_tlast_e;
            if (m_tvalid_z != m_tvalid_e) sync_err++;
            if (m_tvalid_e && m_tready) begin
                if (k < N) begin
                    out_e[k] = m_tdata_e;
                    out_z[k] = m_tdata_z;
                end
                if (m_tuser_e != (k == 0) || m_tuser_z != (k == 0))
                    user_err++;
                if (m_tlast_e != (k == N - 1) ||
                    m_tlast_z != (k == N - 1))
                    last_err++;
                if (m_tlast_e) collect_done = 1'b1;
                k++;
            end
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        ncollected = k;
    endtask

    function automatic int ident_bad();
        int bad = 0;
        for (int i = 0; i < N; i++)
            if (out_z[i] != DW'(i)) bad++;
        return bad;
    endfunction

    task automatic frame_checks(input string tag);
        check({tag, "_done"}, collect_done, 1);
        check({tag, "_count"}, ncollected, N);
        check({tag, "_ident_bad"}, ident_bad(), 0);
        check({tag, "_tuser_err"}, user_err, 0);
        check({tag, "_tlast_err"}, last_err, 0);
        check({tag, "_lockstep"}, sync_err, 0);
        @(negedge clk);
        check({tag, "_tready_back"}, s_tready_e & s_tready_z, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{x: 0,   y: 0,  src: 1680};
        tbl[1] = '{x: 64,  y: 50, src: 6464};
        tbl[2] = '{x: 127, y: 99, src: 11247};
        tbl[3] = '{x: 127, y: 0,  src: 1775};
        tbl[4] = '{x: 0,   y: 99, src: 11152};
        tbl[5] = '{x: 64,  y: 0,  src: 704};
        tbl[6] = '{x: 0,   y: 50, src: 6410};

        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        clear_errs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", s_tready_e, 1);
        check("rst_m_tvalid", m_tvalid_e | m_tvalid_z, 0);
        check("rst_m_tdata", m_tdata_e, 0);
        check("rst_m_tuser_tlast",
              m_tuser_e | m_tlast_e | m_tuser_z | m_tlast_z, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Partial frame, reset, then a resend without tuser.
        send(500, 1'b0, 1'b1, 24'h5A5A5A);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid_in", m_tvalid_e | m_tvalid_z, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_s_tready", s_tready_e, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_errs();
        send(N, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("f1_tready_drop", s_tready_e | s_tready_z, 0);
        check("f1_tready_load", load_rdy_err, 0);
        check("f1_mvalid_load", load_mv_err, 0);
        check("f1_hs_timeout", hs_timeout, 0);
        @(posedge clk);
        #1;
        collect(1'b0);
        frame_checks("f1");
        for (int i = 0; i < 7; i++)
            check($sformatf("map_%0d_%0d", tbl[i].x, tbl[i].y),
                  longint'(out_e[tbl[i].y * W + tbl[i].x]),
                  longint'(tbl[i].src));
        for (int i = 0; i < N; i++) ref_e[i] = out_e[i];

        // Sparse input, random downstream back-pressure.
        clear_errs();
        send(N, 1'b1, 1'b1, '0);
        @(negedge clk);
        check("f2_tready_drop", s_tready_e | s_tready_z, 0);
        check("f2_tready_load", load_rdy_err, 0);
        check("f2_mvalid_load", load_mv_err, 0);
        check("f2_hs_timeout", hs_timeout, 0);
        @(posedge clk);
        #1;
        collect(1'b1);
        frame_checks("f2");
        check("f2_stall_hold", stall_err, 0);
        begin
            int diff = 0;
            for (int i = 0; i < N; i++)
                if (out_e[i] != ref_e[i]) diff++;
            check("f2_vs_f1_diff", diff, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
